// File: rtl/gcd_pkg.sv
// Shared definitions for the sequential GCD controller: FSM state
// encoding, the default operand width and a zero-detect helper.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Operands are zero-extended to 64 bits by the caller, so one helper
    // serves every WIDTH up to 64.
    function automatic logic is_zero(input logic [63:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One compare/subtract step of the GCD datapath: magnitude compare of
// a and b, plus the difference larger-minus-smaller (never borrows).
module gcd_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             b_gt_a,
    output logic             a_eq_b,
    output logic [WIDTH-1:0] diff
);

    // Compare both ways and subtract the smaller from the larger.
    always_comb begin
        a_gt_b = (a > b);
        b_gt_a = (b > a);
        a_eq_b = (a == b);
        diff   = a_gt_b ? (a - b) : (b - a);
    end

endmodule

// File: rtl/gcd_seq_ctrl.sv
// Clocked subtract-based GCD controller. Operands are captured on start
// in IDLE, one compare/subtract step runs per clock in RUN, and the
// result is held in DONE until the requester acknowledges it.
module gcd_seq_ctrl
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [WIDTH-1:0] iter_cnt
);

    state_t           state;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;
    logic             a_gt_b;
    logic             b_gt_a;
    logic             a_eq_b;
    logic [WIDTH-1:0] diff;
    logic             a_zero;
    logic             b_zero;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (rega),
        .b      (regb),
        .a_gt_b (a_gt_b),
        .b_gt_a (b_gt_a),
        .a_eq_b (a_eq_b),
        .diff   (diff)
    );

    // Zero detection on the raw operands decides the start-time shortcut.
    always_comb begin
        a_zero = is_zero(64'(in_a));
        b_zero = is_zero(64'(in_b));
    end

    // FSM, operand registers, step counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rega     <= '0;
            regb     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        if (!a_zero && !b_zero) begin
                            rega  <= in_a;
                            regb  <= in_b;
                            err   <= 1'b0;
                            state <= RUN;
                        end else begin
                            // A zero operand skips RUN: gcd(x,0)=x, and
                            // both-zero is flagged with a zero result.
                            result <= in_a | in_b;
                            err    <= a_zero & b_zero;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (a_eq_b) begin
                        result <= rega;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (a_gt_b) begin
                        rega     <= diff;
                        iter_cnt <= iter_cnt + 1'b1;
                    end else if (b_gt_a) begin
                        regb     <= diff;
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Self-checking bench for gcd_seq_ctrl: directed vectors with literal
// expectations, a transaction-level reference model compared every
// cycle, and a sweep over all WIDTH=4 operand pairs.
module tb_gcd_seq_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned W6 = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ack;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          err;
    logic [W-1:0]  iter_cnt;

    logic          start6;
    logic          ack6;
    logic [W6-1:0] in_a6;
    logic [W6-1:0] in_b6;
    logic          busy6;
    logic          done6;
    logic [W6-1:0] result6;
    logic          err6;
    logic [W6-1:0] iter_cnt6;

    int checks   = 0;
    int failures = 0;

    gcd_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
        .ack(ack), .busy(busy), .done(done), .result(result), .err(err),
        .iter_cnt(iter_cnt)
    );

    gcd_seq_ctrl #(.WIDTH(W6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .in_a(in_a6), .in_b(in_b6),
        .ack(ack6), .busy(busy6), .done(done6), .result(result6), .err(err6),
        .iter_cnt(iter_cnt6)
    );

    always #5 clk = ~clk;

    // Reference: Euclid by remainder for the value, subtraction count
    // for the step number, and the latency rule from the step count.
    function automatic int unsigned ref_gcd(int unsigned a, int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int unsigned ref_steps(int unsigned a, int unsigned b);
        int unsigned n = 0;
        if (a == 0 || b == 0) return 0;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return n;
    endfunction

    function automatic int unsigned ref_lat(int unsigned a, int unsigned b);
        if (a == 0 || b == 0) return 1;
        return ref_steps(a, b) + 2;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 computing, 2 holding result.
    int unsigned m_phase = 0;
    int unsigned m_left  = 0;
    int unsigned m_res   = 0;
    int unsigned m_iter  = 0;
    int unsigned m_err   = 0;
    bit          m_clean = 1'b1;
    bit          mon_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_res   <= 0;
            m_iter  <= 0;
            m_err   <= 0;
            m_clean <= 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_clean <= 1'b0;
                    m_res   <= ref_gcd(32'(in_a), 32'(in_b));
                    m_iter  <= ref_steps(32'(in_a), 32'(in_b));
                    m_err   <= (in_a == 0 && in_b == 0) ? 1 : 0;
                    if (in_a == 0 || in_b == 0) begin
                        m_phase <= 2;
                    end else begin
                        m_phase <= 1;
                        m_left  <= ref_steps(32'(in_a), 32'(in_b)) + 1;
                    end
                end
                1: begin
                    if (m_left == 1) m_phase <= 2;
                    m_left <= m_left - 1;
                end
                default: if (ack) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
            check("done", 32'(done), (m_phase == 2) ? 1 : 0);
            if (m_phase == 2) begin
                check("result", 32'(result), m_res);
                check("iter_cnt", 32'(iter_cnt), m_iter);
                check("err", 32'(err), m_err);
            end else if (m_clean) begin
                check("reset_result", 32'(result), 0);
                check("reset_iter", 32'(iter_cnt), 0);
                check("reset_err", 32'(err), 0);
            end
        end
    end

    // Present operands for one cycle, then count cycles until done.
    task automatic launch(input int unsigned a, input int unsigned b, output int unsigned lat);
        @(negedge clk);
        in_a  = W'(a);
        in_b  = W'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        lat   = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_and_check(input string name);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({name, "_ack_done"}, 32'(done), 0);
        check({name, "_ack_busy"}, 32'(busy), 0);
    endtask

    task automatic run_op(input string name, input int unsigned a, input int unsigned b,
                          input int unsigned e_res, input int unsigned e_iter,
                          input int unsigned e_err, input int unsigned e_lat);
        int unsigned lat;
        check({name, "_model_res"}, ref_gcd(a, b), e_res);
        check({name, "_model_iter"}, ref_steps(a, b), e_iter);
        check({name, "_model_lat"}, ref_lat(a, b), e_lat);
        launch(a, b, lat);
        check({name, "_lat"}, lat, e_lat);
        check({name, "_res"}, 32'(result), e_res);
        check({name, "_iter"}, 32'(iter_cnt), e_iter);
        check({name, "_err"}, 32'(err), e_err);
    endtask

    initial begin
        int unsigned lat;
        rst = 1'b1; start = 1'b0; ack = 1'b0; in_a = '0; in_b = '0;
        start6 = 1'b0; ack6 = 1'b0; in_a6 = '0; in_b6 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_iter", 32'(iter_cnt), 0);

        // Reset in the middle of gcd(15,1), then a clean (6,4).
        @(negedge clk);
        in_a = 4'd15; in_b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result", 32'(result), 0);
        check("abort_iter", 32'(iter_cnt), 0);
        run_op("g6_4", 6, 4, 2, 2, 0, 4);
        ack_and_check("g6_4");

        // Result held across a delayed ack.
        run_op("g12_8", 12, 8, 4, 2, 0, 4);
        repeat (5) begin
            @(negedge clk);
            check("hold_done", 32'(done), 1);
            check("hold_result", 32'(result), 4);
            check("hold_iter", 32'(iter_cnt), 2);
        end
        ack_and_check("g12_8");

        run_op("g9_9", 9, 9, 9, 0, 0, 2);
        ack_and_check("g9_9");
        run_op("g0_7", 0, 7, 7, 0, 0, 1);
        ack_and_check("g0_7");
        run_op("g5_0", 5, 0, 5, 0, 0, 1);
        ack_and_check("g5_0");
        run_op("g0_0", 0, 0, 0, 0, 1, 1);
        ack_and_check("g0_0");
        run_op("g1_15", 1, 15, 1, 14, 0, 16);
        ack_and_check("g1_15");

        // start while busy is ignored; start together with ack does not launch.
        @(negedge clk);
        in_a = 4'd10; in_b = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_a = 4'd3; in_b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("busystart_lat", lat, 5);
        check("busystart_res", 32'(result), 2);
        check("busystart_iter", 32'(iter_cnt), 3);
        in_a = 4'd3; in_b = 4'd5; start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        check("startack_busy", 32'(busy), 0);
        check("startack_done", 32'(done), 0);
        repeat (3) begin
            @(negedge clk);
            check("startack_idle", 32'(busy), 0);
        end

        // Worst case at WIDTH=6.
        @(negedge clk);
        in_a6 = 6'd63; in_b6 = 6'd1; start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        lat = 1;
        while (!done6 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("w6_lat", lat, 64);
        check("w6_res", 32'(result6), 1);
        check("w6_iter", 32'(iter_cnt6), 62);
        check("w6_err", 32'(err6), 0);
        ack6 = 1'b1;
        @(negedge clk);
        ack6 = 1'b0;
        check("w6_ack_done", 32'(done6), 0);

        // Every WIDTH=4 pair, random ack delay, starting at a random pair.
        begin
            int unsigned off = $urandom_range(0, 255);
            for (int unsigned k = 0; k < 256; k++) begin
                int unsigned p = (k + off) % 256;
                int unsigned a = p / 16;
                int unsigned b = p % 16;
                launch(a, b, lat);
                check("sweep_lat", lat, ref_lat(a, b));
                check("sweep_res", 32'(result), ref_gcd(a, b));
                check("sweep_iter", 32'(iter_cnt), ref_steps(a, b));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ack_and_check("sweep");
            end
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
